// File: rtl/shot_clock_pkg.sv
// Shared constants and types for the shot-clock input path: debounce timing
// and the reset-pulse FSM encoding.
package shot_clock_pkg;

   localparam int CLK_HZ                  = 50_000_000;
   localparam int DEBOUNCE_MS             = 20;
   localparam int DEBOUNCE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;

   localparam logic RST_IDLE_CODE  = 1'b0;
   localparam logic RST_PULSE_CODE = 1'b1;

   typedef enum logic {
      RST_IDLE  = RST_IDLE_CODE,
      RST_PULSE = RST_PULSE_CODE
   } rst_state_t;

   // Counter width able to hold 0 .. n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_sync.sv
// One input channel: 2-flop synchroniser, stability counter and the accepted
// (debounced) level.
module debounce_sync
   import shot_clock_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic RESET_LEVEL     = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level
);

   localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_a;
   logic          sync_b;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_a <= RESET_LEVEL;
         sync_b <= RESET_LEVEL;
         level  <= RESET_LEVEL;
         cnt    <= '0;
      end else begin
         sync_a <= raw;
         sync_b <= sync_a;
         // Any cycle of agreement restarts the stability window.
         if (sync_b == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_b;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/shot_clock_input_conditioner.sv
// Conditions the DE10-Lite reset/pause keys and mode switch into the reset
// pulse, pause level and mode level consumed by the shot-clock core.
module shot_clock_input_conditioner
   import shot_clock_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_DEFAULT,
   parameter int RST_PULSE_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic key_reset_n,
   input  logic key_pause_n,
   input  logic sw_mode,
   output logic sc_rst,
   output logic sc_pause,
   output logic sc_mode
);

   localparam int            PW         = cnt_width(RST_PULSE_CYCLES + 1);
   localparam logic [PW-1:0] PULSE_LOAD = PW'(RST_PULSE_CYCLES);

   logic key_reset_db, key_pause_db, mode_db;
   logic key_reset_prev, key_pause_prev, mode_prev;
   logic press_reset, press_pause, mode_chg, clear_evt;

   rst_state_t    state, state_next;
   logic [PW-1:0] pulse_cnt, pulse_cnt_next;

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key_reset (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_reset_n),
      .level (key_reset_db)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b1)) u_key_pause (
      .clk   (clk),
      .rst   (rst),
      .raw   (key_pause_n),
      .level (key_pause_db)
   );

   debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_sw_mode (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_mode),
      .level (mode_db)
   );

   // Keys are active-low: only the debounced 1->0 edge is a press.
   assign press_reset = key_reset_prev & ~key_reset_db;
   assign press_pause = key_pause_prev & ~key_pause_db;
   assign mode_chg    = mode_prev ^ mode_db;
   assign clear_evt   = press_reset | mode_chg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         key_reset_prev <= 1'b1;
         key_pause_prev <= 1'b1;
         mode_prev      <= 1'b0;
         sc_pause       <= 1'b0;
      end else begin
         key_reset_prev <= key_reset_db;
         key_pause_prev <= key_pause_db;
         mode_prev      <= mode_db;
         if (clear_evt) begin
            sc_pause <= 1'b0;
         end else if (press_pause) begin
            sc_pause <= ~sc_pause;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= RST_IDLE;
         pulse_cnt <= '0;
      end else begin
         state     <= state_next;
         pulse_cnt <= pulse_cnt_next;
      end
   end

   // A trigger always reloads, so overlapping triggers stretch one pulse.
   always_comb begin
      state_next     = state;
      pulse_cnt_next = pulse_cnt;
      if (clear_evt) begin
         state_next     = RST_PULSE;
         pulse_cnt_next = PULSE_LOAD;
      end else if (state == RST_PULSE) begin
         if (pulse_cnt <= PW'(1)) begin
            state_next     = RST_IDLE;
            pulse_cnt_next = '0;
         end else begin
            pulse_cnt_next = pulse_cnt - PW'(1);
         end
      end
   end

   assign sc_rst  = (state == RST_PULSE);
   assign sc_mode = mode_db;

endmodule

// File: tb/tb_shot_clock_input_conditioner.sv
// Scoreboard bench for shot_clock_input_conditioner with DEBOUNCE_CYCLES=8,
// RST_PULSE_CYCLES=2; expected {sc_rst, sc_pause, sc_mode} per cycle.
module tb_shot_clock_input_conditioner;

   localparam int DB       = 8;
   localparam int PULSE    = 2;
   // Edges from a pin change to the registered outputs / to sc_mode.
   localparam int LAT      = 2 + DB + 1;
   localparam int MODE_LAT = 2 + DB;

   logic clk;
   logic rst;
   logic key_reset_n;
   logic key_pause_n;
   logic sw_mode;
   logic sc_rst;
   logic sc_pause;
   logic sc_mode;

   logic [2:0] exp_q[$];
   int         n_cmp;
   int         n_bad;

   shot_clock_input_conditioner #(
      .DEBOUNCE_CYCLES  (DB),
      .RST_PULSE_CYCLES (PULSE)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_reset_n (key_reset_n),
      .key_pause_n (key_pause_n),
      .sw_mode     (sw_mode),
      .sc_rst      (sc_rst),
      .sc_pause    (sc_pause),
      .sc_mode     (sc_mode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Applies one cycle of pin levels and queues the outputs expected after
   // the next rising edge.
   task automatic drive(input logic r, input logic kr, input logic kp,
                        input logic sw, input logic [2:0] e);
      rst         = r;
      key_reset_n = kr;
      key_pause_n = kp;
      sw_mode     = sw;
      exp_q.push_back(e);
   endtask

   function automatic logic in_pulse(input int c);
      return (c >= LAT - 1) && (c < LAT - 1 + PULSE);
   endfunction

   task automatic test_reset();
      logic [2:0] e;
      logic [2:0] got;
      for (int i = 0; i < 53; i++) begin
         drive((i < 3) ? 1'b0 : 1'b1, 1'b1, 1'b1, 1'b0, 3'b000);
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_reset i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_pause_bounce();
      logic [2:0] e;
      logic [2:0] got;
      logic       kp;
      logic       p;
      int         c;
      for (int i = 0; i < 78; i++) begin
         if (i < 18) begin
            kp = ((i % 6) < 3) ? 1'b0 : 1'b1;
            p  = 1'b0;
         end else if (i < 48) begin
            c  = i - 18;
            kp = (c < 10) ? 1'b0 : 1'b1;
            p  = (c >= LAT - 1);
         end else begin
            c  = i - 48;
            kp = (c < 10) ? 1'b0 : 1'b1;
            p  = (c < LAT - 1);
         end
         drive(1'b1, 1'b1, kp, 1'b0, {1'b0, p, 1'b0});
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_pause_bounce i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_glitch_reject();
      logic [2:0] e;
      logic [2:0] got;
      for (int i = 0; i < 140; i++) begin
         drive(1'b1, ((i % 14) < DB - 1) ? 1'b0 : 1'b1, 1'b1, 1'b0, 3'b000);
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_glitch_reject i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_reset_while_paused();
      logic [2:0] e;
      logic [2:0] got;
      int         c;
      for (int i = 0; i < 60; i++) begin
         c = (i < 30) ? i : i - 30;
         if (i < 30)
            drive(1'b1, 1'b1, (c < 10) ? 1'b0 : 1'b1, 1'b0, {1'b0, (c >= LAT - 1), 1'b0});
         else
            drive(1'b1, (c < 10) ? 1'b0 : 1'b1, 1'b1, 1'b0,
                  {in_pulse(c), (c < LAT - 1), 1'b0});
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_reset_while_paused i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_mode_change();
      logic [2:0] e;
      logic [2:0] got;
      int         c;
      for (int i = 0; i < 90; i++) begin
         c = i % 30;
         if (i < 30)
            drive(1'b1, 1'b1, (c < 10) ? 1'b0 : 1'b1, 1'b0, {1'b0, (c >= LAT - 1), 1'b0});
         else if (i < 60)
            drive(1'b1, 1'b1, 1'b1, 1'b1,
                  {in_pulse(c), (c < LAT - 1), (c >= MODE_LAT - 1)});
         else
            drive(1'b1, 1'b1, 1'b1, 1'b0, {in_pulse(c), 1'b0, (c < MODE_LAT - 1)});
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_mode_change i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [2:0] e;
      logic [2:0] got;
      logic       k;
      int         c;
      for (int i = 0; i < 60; i++) begin
         c = i % 30;
         k = (c < 10) ? 1'b0 : 1'b1;
         if (i < 30)
            drive(1'b1, k, k, 1'b0, {in_pulse(c), 1'b0, 1'b0});
         else
            drive(1'b1, k, 1'b1, 1'b1, {in_pulse(c), 1'b0, (c >= MODE_LAT - 1)});
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_simultaneous i=%0d rst/pause/mode got %b expected %b", i, got, e);
         end
      end
   endtask

   task automatic test_reset_mid_pulse();
      logic [2:0] e;
      logic [2:0] got;
      int         r;
      for (int c = 0; c < 43; c++) begin
         r = c - 13;
         if (c <= 10)
            drive(1'b1, 1'b0, 1'b1, 1'b1, {(c == LAT - 1), 1'b0, 1'b1});
         else if (c <= 12)
            drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
         else
            drive(1'b1, 1'b1, 1'b1, 1'b1, {in_pulse(r), 1'b0, (r >= MODE_LAT - 1)});
         @(posedge clk); #1;
         e   = exp_q.pop_front();
         got = {sc_rst, sc_pause, sc_mode};
         n_cmp++;
         if (got !== e) begin
            n_bad++;
            $display("FAIL test_reset_mid_pulse c=%0d rst/pause/mode got %b expected %b", c, got, e);
         end
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_bad       = 0;
      rst         = 1'b0;
      key_reset_n = 1'b1;
      key_pause_n = 1'b1;
      sw_mode     = 1'b0;
      @(negedge clk);
      test_reset();
      test_pause_bounce();
      test_glitch_reject();
      test_reset_while_paused();
      test_mode_change();
      test_simultaneous();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/shot_clock_input_conditioner.md
# shot_clock_input_conditioner

Input conditioning stage directly upstream of the shot-clock top level on the DE10-Lite. It synchronises and debounces the two push-buttons (active-low KEYs) and the mode slide switch. It converts them into the control signals the shot-clock core consumes:
- an active-high reset pulse;
- a latched pause level that toggles on each press;
- a debounced mode level.

A change of mode also forces a reset, so the core always reloads its new start value.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a new input level (20 ms at 50 MHz).
- `RST_PULSE_CYCLES`, default 2: width of the `sc_rst` pulse, in cycles.

Ports:
- `clk`  in  1  50 MHz system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-low.
- `key_reset_n`  in  1  raw reset push-button, low = pressed, asynchronous.
- `key_pause_n`  in  1  raw pause push-button, low = pressed, asynchronous.
- `sw_mode`  in  1  raw mode slide switch, asynchronous (0 = 24 s, 1 = 30 s).
- `sc_rst`  out  1  active-high reset to the shot-clock core.
- `sc_pause`  out  1  pause level to the core (1 = frozen).
- `sc_mode`  out  1  debounced mode level to the core.

## Operation
- **Per channel:**
  - 2-flop synchroniser.
  - Debounce counter, width ceil(log2(DEBOUNCE_CYCLES)).
  - Debounced state register.
- **Debounce rule:**
  - Counter increments each cycle that the synchronised level differs from the debounced state.
  - Counter clears on any cycle the two are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced state flips on the next edge and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never propagate.
- **Events**, one-cycle internal strobes generated from the debounced states:
  - `press_reset`: `key_reset` debounced 1→0.
  - `press_pause`: `key_pause` debounced 1→0.
  - `mode_chg`: any debounced `sw_mode` transition.
- Releases (0→1) of either key generate no event.
- **Pause latch:**
  - `press_pause` toggles `sc_pause`.
  - `press_reset` or `mode_chg` clears `sc_pause` to 0.
  - Clear has priority over toggle when both occur in the same cycle.
- **Reset pulse generator** (states IDLE and PULSE, down-counter):
  - `press_reset` or `mode_chg` enters PULSE with count = RST_PULSE_CYCLES.
  - `sc_rst` = 1 while in PULSE.
  - Returns to IDLE when the count reaches 0.
  - A new trigger while in PULSE reloads the count, extending the pulse.
- `sc_mode` follows the debounced `sw_mode` state directly.

## Timing
- **Reset values** (`rst` low at a rising edge):
  - Synchronisers and debounced key states = 1 (released).
  - Debounced mode = 0.
  - Counters = 0.
  - FSM = IDLE.
  - `sc_rst` = 0, `sc_pause` = 0, `sc_mode` = 0.
- **Pin to output latency:**
  - Raw pin change, then 2 cycles to the synchroniser output.
  - Then DEBOUNCE_CYCLES cycles to the debounced flip.
  - Then 1 cycle to `sc_pause` / `sc_rst` assertion (registered outputs).
  - `sc_mode` asserts at the debounced flip (no extra register).
- **Switch high at power-up:** if `sw_mode` is high when `rst` releases, `sc_mode` rises after debounce and one `sc_rst` pulse is issued. This is intended behaviour.
- **Reset mid-operation:** `rst` low mid-pulse or mid-debounce aborts immediately. All state returns to its reset values on that edge. No residual pulse is emitted.
- **Simultaneous `press_reset` and `press_pause`:** `sc_pause` = 0 and `sc_rst` pulses.
- **`mode_chg` and `press_reset` in the same cycle:** a single pulse of RST_PULSE_CYCLES.

## Structure
- Shared package `shot_clock_pkg` holds:
  - `CLK_HZ` = 50_000_000;
  - `DEBOUNCE_MS` = 20;
  - derived `DEBOUNCE_CYCLES_DEFAULT`;
  - localparams for the reset-FSM state encoding (`RST_IDLE`, `RST_PULSE`).
- Sub-module `debounce_sync` contains one synchroniser, counter and debounced-state channel.
  - Parameters: `DEBOUNCE_CYCLES` and `RESET_LEVEL`.
  - Instantiated three times.
- Edge detection, pause latch and the reset FSM live in the top of this block.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and RST_PULSE_CYCLES=2.

1. **Reset values:** hold `rst` low for 3 cycles with all inputs idle. Then all outputs are 0 and stay 0 for 50 cycles.
2. **Pause toggle with bounce:**
   - Stimulus: `key_pause_n` low with 3-cycle glitches, then held stable low for 10 cycles, then released.
   - Response: `sc_pause` rises exactly 11 cycles after the stable low begins (2 + 8 + 1) and stays 1 after release.
   - A second clean press returns `sc_pause` to 0.
3. **Glitch rejection:** 7-cycle low pulses on `key_reset_n`, repeated 10 times. `sc_rst` never asserts.
4. **Reset press while paused:**
   - Stimulus: with `sc_pause` = 1, give a clean `key_reset_n` press.
   - Response: `sc_rst` is high for exactly 2 cycles and `sc_pause` drops to 0 on the same edge that `sc_rst` rises.
5. **Mode change:** toggle `sw_mode` 0→1, held stable. `sc_mode` rises after 10 cycles, `sc_rst` pulses for 2 cycles starting the next cycle, and `sc_pause` = 0.
6. **Simultaneous and mid-operation events:**
   - Pause and reset pressed in the same cycle: `sc_pause` = 0 and a single 2-cycle `sc_rst`.
   - `rst` driven low during an `sc_rst` pulse: `sc_rst` = 0 on the next edge.
